// File: rtl/pwm_multi_channel_if.sv
// pwm_multi_channel_if: control/status bundle between a PWM host and pwm_multi_channel
interface pwm_multi_channel_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int CH_W     = 2
);
  logic                enable;
  logic [2:0]          presc_sel;
  logic                center_mode;
  logic                wr_en;
  logic [CH_W-1:0]     wr_ch;
  logic [WIDTH-1:0]    wr_duty;
  logic [CHANNELS-1:0] invert;
  logic [CHANNELS-1:0] pwm_out;
  logic                period_start;
  logic [CHANNELS-1:0] update_pending;
  modport master (
    output enable, presc_sel, center_mode, wr_en, wr_ch, wr_duty, invert,
    input  pwm_out, period_start, update_pending
  );
  modport slave (
    input  enable, presc_sel, center_mode, wr_en, wr_ch, wr_duty, invert,
    output pwm_out, period_start, update_pending
  );
endinterface

// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: shared-counter multi-channel PWM with prescaler, edge/center modes and double-buffered duty
module pwm_multi_channel #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int CH_W     = 2
) (
  input  logic clk,
  input  logic rst,
  pwm_multi_channel_if.slave bus
);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  logic [6:0]          presc_q, presc_d, lim;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic                dir_q, dir_d;
  logic                mode_q, mode_d;
  logic [WIDTH-1:0]    shadow_q [CHANNELS];
  logic [WIDTH-1:0]    shadow_d [CHANNELS];
  logic [WIDTH-1:0]    active_q [CHANNELS];
  logic [WIDTH-1:0]    active_d [CHANNELS];
  logic [CHANNELS-1:0] pending_q, pending_d, pwm_q, pwm_d, wr_hit, raw;
  logic                ps_q, ps_d, tick, boundary;
  // prescaler: a >= compare lets a shrinking presc_sel tick and wrap on the very next clock
  always_comb begin
    lim     = 7'((8'd1 << bus.presc_sel) - 8'd1);
    tick    = bus.enable && (presc_q >= lim);
    presc_d = (!bus.enable || tick) ? '0 : presc_q + 7'd1;
  end
  // shared counter: edge mode wraps at max, center mode bounces; the mode only changes at a boundary
  always_comb begin
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    mode_d   = mode_q;
    boundary = 1'b0;
    if (!bus.enable) begin
      cnt_d  = '0;
      dir_d  = 1'b0;
      mode_d = bus.center_mode;
    end else if (tick) begin
      if (!mode_q) begin
        cnt_d    = cnt_q + ONE;
        boundary = (cnt_q == CNT_MAX);
      end else if (!dir_q) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q - ONE : cnt_q + ONE;
        dir_d = (cnt_q == CNT_MAX);
      end else begin
        cnt_d    = cnt_q - ONE;
        boundary = (cnt_q == ONE);
      end
      if (boundary) begin
        mode_d = bus.center_mode;
        dir_d  = 1'b0;
      end
    end
  end
  // per-channel duty buffering and compare; active loads the pre-write shadow at a boundary
  always_comb begin
    wr_hit    = '0;
    pending_d = '0;
    raw       = '0;
    pwm_d     = '0;
    shadow_d  = shadow_q;
    active_d  = active_q;
    ps_d      = boundary;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_hit[i]    = bus.wr_en && (bus.wr_ch == CH_W'(i));
      shadow_d[i]  = wr_hit[i] ? bus.wr_duty : shadow_q[i];
      active_d[i]  = (!bus.enable || boundary) ? shadow_q[i] : active_q[i];
      pending_d[i] = bus.enable && ((pending_q[i] && !boundary) || wr_hit[i]);
      raw[i]       = bus.enable && (cnt_q < active_q[i]);
      pwm_d[i]     = raw[i] ^ bus.invert[i];
    end
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      mode_q    <= 1'b0;
      shadow_q  <= '{default: '0};
      active_q  <= '{default: '0};
      pending_q <= '0;
      pwm_q     <= '0;
      ps_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      mode_q    <= mode_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pwm_q     <= pwm_d;
      ps_q      <= ps_d;
    end
  end
  assign bus.pwm_out        = pwm_q;
  assign bus.period_start   = ps_q;
  assign bus.update_pending = pending_q;
endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb_pwm_multi_channel: directed checks of pwm_multi_channel with hand-computed expectations
module tb_pwm_multi_channel;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  int   hi [4];
  int   ps_cnt, first_ps;
  pwm_multi_channel_if #(.CHANNELS(4), .WIDTH(8), .CH_W(3)) bus ();
  pwm_multi_channel #(.CHANNELS(4), .WIDTH(8), .CH_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int ch, input int duty);
    bus.wr_en   = 1'b1;
    bus.wr_ch   = 3'(ch);
    bus.wr_duty = 8'(duty);
    step();
    bus.wr_en   = 1'b0;
  endtask
  task automatic run(input int n);
    for (int c = 0; c < 4; c++) hi[c] = 0;
    ps_cnt   = 0;
    first_ps = 0;
    for (int k = 0; k < n; k++) begin
      step();
      for (int c = 0; c < 4; c++) hi[c] += int'(bus.pwm_out[c]);
      if (bus.period_start) begin
        ps_cnt++;
        if (first_ps == 0) first_ps = k + 1;
      end
    end
  endtask
  initial begin
    bus.enable = 1'b0; bus.presc_sel = 3'd0; bus.center_mode = 1'b0;
    bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_duty = '0; bus.invert = '0;
    step(); step();
    check("rst_pwm", int'(bus.pwm_out), 0);
    check("rst_ps", int'(bus.period_start), 0);
    check("rst_pend", int'(bus.update_pending), 0);
    rst = 1'b0;
    // duties loaded while idle; idle level follows invert
    wr(0, 64); wr(1, 0); wr(2, 255); step();
    check("idle_pend", int'(bus.update_pending), 0);
    bus.invert = 4'b1010; step();
    check("idle_inv", int'(bus.pwm_out), 4'b1010);
    bus.invert = 4'b0000; step();
    check("idle_low", int'(bus.pwm_out), 0);
    bus.enable = 1'b1;
    run(256);
    check("e_hi0", hi[0], 64);
    check("e_hi1", hi[1], 0);
    check("e_hi2", hi[2], 255);
    check("e_ps", ps_cnt, 1);
    check("e_first_ps", first_ps, 256);
    run(256);
    check("e2_hi0", hi[0], 64);
    check("e2_ps", ps_cnt, 1);
    // mid-period write at cnt=100: rest of the period (cnt 101..255) stays on duty 64
    run(100);
    wr(0, 192);
    check("mid_pend", int'(bus.update_pending), 4'b0001);
    run(155);
    check("mid_hi0", hi[0], 0);
    check("mid_first_ps", first_ps, 155);
    check("mid_pend_clr", int'(bus.update_pending), 0);
    run(256);
    check("new_hi0", hi[0], 192);
    check("new_ps", ps_cnt, 1);
    // write landing on the boundary edge (cnt=255)
    run(255);
    wr(1, 50);
    check("bnd_ps", int'(bus.period_start), 1);
    check("bnd_pend", int'(bus.update_pending), 4'b0010);
    run(256);
    check("bnd_hi1_old", hi[1], 0);
    check("bnd_pend_clr", int'(bus.update_pending), 0);
    run(256);
    check("bnd_hi1_new", hi[1], 50);
    // prescaler /8: each count held 8 clocks
    bus.enable = 1'b0; step();
    bus.presc_sel = 3'd3; wr(0, 128); step();
    bus.enable = 1'b1;
    run(2048);
    check("p3_hi0", hi[0], 1024);
    check("p3_ps", ps_cnt, 1);
    check("p3_first_ps", first_ps, 2048);
    // presc_cnt=4, cnt=2 here; dropping to /1 ticks at once (cnt=3), boundary after cnt 3..255
    run(20);
    bus.presc_sel = 3'd0; step();
    run(253);
    check("p0_first_ps", first_ps, 253);
    check("p0_ps", ps_cnt, 1);
    // center mode requested mid-period takes effect only at the next edge-mode boundary
    bus.enable = 1'b0; wr(0, 100); step();
    bus.enable = 1'b1;
    run(50);
    bus.center_mode = 1'b1;
    run(206);
    check("c_switch_ps", first_ps, 206);
    // per 510-tick period cnt 0 occurs once and 1..99 twice: 199 high
    run(510);
    check("c_hi0", hi[0], 199);
    check("c_ps", ps_cnt, 1);
    check("c_first_ps", first_ps, 510);
    bus.invert = 4'b0001;
    run(510);
    check("c_inv_hi0", hi[0], 311);
    check("c_inv_ps", first_ps, 510);
    // reset mid-period overrides enable and a concurrent write
    wr(2, 77);
    check("pre_rst_pend", int'(bus.update_pending), 4'b0100);
    rst = 1'b1; bus.wr_en = 1'b1; bus.wr_ch = 3'd0; bus.wr_duty = 8'd9;
    step();
    check("mid_rst_pwm", int'(bus.pwm_out), 0);
    check("mid_rst_pend", int'(bus.update_pending), 0);
    check("mid_rst_ps", int'(bus.period_start), 0);
    rst = 1'b0; bus.wr_en = 1'b0; bus.invert = 4'b0000;
    run(256);
    check("post_rst_first_ps", first_ps, 256);
    check("post_rst_hi0", hi[0], 0);
    check("post_rst_hi2", hi[2], 0);
    // out-of-range channel indices are ignored
    wr(5, 99);
    check("oor5_pend", int'(bus.update_pending), 0);
    wr(4, 99);
    check("oor4_pend", int'(bus.update_pending), 0);
    run(300);
    check("oor_hi", hi[0] + hi[1] + hi[2] + hi[3], 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
